// File: rtl/memory_arbiter_if.sv
// Signal bundle between two memory requesters, the arbiter and the shared memory bus.
// The slave modport is the arbiter's view; master is the requester/bus side.
interface memory_arbiter_if;
    logic        req_0, req_1;
    logic        we_0, we_1;
    logic [15:0] address_0, address_1;
    logic [31:0] data_in_0, data_in_1;
    logic [3:0]  write_mask_0, write_mask_1;
    logic        ready_0, ready_1;
    logic [31:0] data_out_0, data_out_1;
    logic [15:0] bus_address;
    logic [31:0] bus_data_in;
    logic [3:0]  bus_write_mask;
    logic        bus_enable, bus_write_enable;
    logic [31:0] bus_data_out;
    logic [1:0]  grant;

    modport slave (
        input  req_0, req_1, we_0, we_1, address_0, address_1,
               data_in_0, data_in_1, write_mask_0, write_mask_1, bus_data_out,
        output ready_0, ready_1, data_out_0, data_out_1, bus_address,
               bus_data_in, bus_write_mask, bus_enable, bus_write_enable, grant
    );

    modport master (
        output req_0, req_1, we_0, we_1, address_0, address_1,
               data_in_0, data_in_1, write_mask_0, write_mask_1, bus_data_out,
        input  ready_0, ready_1, data_out_0, data_out_1, bus_address,
               bus_data_in, bus_write_mask, bus_enable, bus_write_enable, grant
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port arbiter onto a single memory bus: one transaction at a time, bus held for
// WAIT_CYCLES cycles, then a one-cycle ready pulse to the owner.
module memory_arbiter #(
    parameter int WAIT_CYCLES    = 2,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic            clk,
    input  logic            reset,
    memory_arbiter_if.slave mif
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] dout0_q, dout0_d;
    logic [31:0] dout1_q, dout1_d;
    logic        pick_1;
    logic        in_access;
    logic        in_done;

    // last_q = 1 means port 1 owned the previous transaction, so port 0 wins the next tie.
    always_comb begin
        pick_1 = mif.req_1;
        if (mif.req_0 && mif.req_1) begin
            pick_1 = (FIXED_PRIORITY == 0) && !last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                if (mif.req_0 || mif.req_1) begin
                    state_d = ACCESS;
                    grant_d = pick_1 ? 2'b10 : 2'b01;
                    cnt_d   = CNT_LOAD;
                    we_d    = pick_1 ? mif.we_1 : mif.we_0;
                    addr_d  = pick_1 ? mif.address_1 : mif.address_0;
                    wdata_d = pick_1 ? mif.data_in_1 : mif.data_in_0;
                    mask_d  = pick_1 ? mif.write_mask_1 : mif.write_mask_0;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    last_d  = grant_q[1];
                    if (!we_q && grant_q[0]) dout0_d = mif.bus_data_out;
                    if (!we_q && grant_q[1]) dout1_d = mif.bus_data_out;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    // Latched request fields are only observed while in ACCESS, so they carry no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        mask_q  <= mask_d;
    end

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    assign mif.bus_enable       = in_access;
    assign mif.bus_write_enable = in_access & we_q;
    assign mif.bus_address      = in_access ? addr_q  : 16'h0000;
    assign mif.bus_data_in      = in_access ? wdata_q : 32'h0000_0000;
    assign mif.bus_write_mask   = in_access ? mask_q  : 4'h0;
    assign mif.ready_0          = in_done & grant_q[0];
    assign mif.ready_1          = in_done & grant_q[1];
    assign mif.grant            = grant_q;
    assign mif.data_out_0       = dout0_q;
    assign mif.data_out_1       = dout1_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: three instances (round-robin W=2, fixed-priority W=2,
// round-robin W=1) share one stimulus stream and are checked against a transaction model.
module tb_memory_arbiter;
    localparam int N = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_0, req_1, we_0, we_1;
    logic [15:0] address_0, address_1;
    logic [31:0] data_in_0, data_in_1;
    logic [3:0]  write_mask_0, write_mask_1;
    logic [31:0] bus_data_out;

    logic [1:0]  grant_a [N];
    logic        rdy0_a  [N];
    logic        rdy1_a  [N];
    logic        ben_a   [N];
    logic        bwe_a   [N];
    logic [31:0] dout0_a [N];
    logic [31:0] dout1_a [N];
    logic [31:0] bdin_a  [N];
    logic [15:0] badr_a  [N];
    logic [3:0]  bmsk_a  [N];

    for (genvar k = 0; k < N; k++) begin : g_dut
        memory_arbiter_if mif ();
        assign mif.req_0        = req_0;
        assign mif.req_1        = req_1;
        assign mif.we_0         = we_0;
        assign mif.we_1         = we_1;
        assign mif.address_0    = address_0;
        assign mif.address_1    = address_1;
        assign mif.data_in_0    = data_in_0;
        assign mif.data_in_1    = data_in_1;
        assign mif.write_mask_0 = write_mask_0;
        assign mif.write_mask_1 = write_mask_1;
        assign mif.bus_data_out = bus_data_out;
        assign grant_a[k] = mif.grant;
        assign rdy0_a[k]  = mif.ready_0;
        assign rdy1_a[k]  = mif.ready_1;
        assign ben_a[k]   = mif.bus_enable;
        assign bwe_a[k]   = mif.bus_write_enable;
        assign dout0_a[k] = mif.data_out_0;
        assign dout1_a[k] = mif.data_out_1;
        assign bdin_a[k]  = mif.bus_data_in;
        assign badr_a[k]  = mif.bus_address;
        assign bmsk_a[k]  = mif.bus_write_mask;

        memory_arbiter #(
            .WAIT_CYCLES    ((k == 2) ? 1 : 2),
            .FIXED_PRIORITY ((k == 1) ? 1 : 0)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .mif   (mif.slave)
        );
    end

    function automatic int wc(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic bit fp(input int k);
        return (k == 1);
    endfunction

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h at t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Transaction model: a grant starts a transaction whose age counts cycles since the grant;
    // ages 1..W are bus cycles, age W+1 is the ready cycle.
    bit          m_started = 1'b0;
    bit          m_busy [N];
    int          m_age  [N];
    int          m_own  [N];
    int          m_last [N];
    logic        m_we   [N];
    logic [15:0] m_addr [N];
    logic [31:0] m_wd   [N];
    logic [3:0]  m_msk  [N];
    logic [31:0] m_d0   [N];
    logic [31:0] m_d1   [N];

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                m_busy[k] = 1'b0;
                m_age[k]  = 0;
                m_last[k] = 1;
                m_d0[k]   = 32'h0;
                m_d1[k]   = 32'h0;
            end else if (!m_busy[k]) begin
                if (req_0 || req_1) begin
                    if (req_0 && req_1) m_own[k] = (fp(k) || m_last[k] == 1) ? 0 : 1;
                    else                m_own[k] = req_1 ? 1 : 0;
                    m_we[k]   = (m_own[k] == 1) ? we_1 : we_0;
                    m_addr[k] = (m_own[k] == 1) ? address_1 : address_0;
                    m_wd[k]   = (m_own[k] == 1) ? data_in_1 : data_in_0;
                    m_msk[k]  = (m_own[k] == 1) ? write_mask_1 : write_mask_0;
                    m_busy[k] = 1'b1;
                    m_age[k]  = 1;
                end
            end else if (m_age[k] == wc(k)) begin
                if (!m_we[k] && m_own[k] == 0) m_d0[k] = bus_data_out;
                if (!m_we[k] && m_own[k] == 1) m_d1[k] = bus_data_out;
                m_last[k] = m_own[k];
                m_age[k]  = m_age[k] + 1;
            end else if (m_age[k] > wc(k)) begin
                m_busy[k] = 1'b0;
            end else begin
                m_age[k] = m_age[k] + 1;
            end
        end
        m_started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit         rec = 1'b0;
    logic [1:0] prev_g [N];
    logic [1:0] gq_rr [$];
    logic [1:0] gq_fp [$];

    initial forever begin
        logic       acc, dn;
        logic [1:0] eg;
        @(negedge clk);
        if (m_started) begin
            for (int k = 0; k < N; k++) begin
                acc = m_busy[k] && (m_age[k] <= wc(k));
                dn  = m_busy[k] && (m_age[k] > wc(k));
                eg  = !m_busy[k] ? 2'b00 : ((m_own[k] == 1) ? 2'b10 : 2'b01);
                chk("grant",            k, 32'(grant_a[k]), 32'(eg));
                chk("ready_0",          k, 32'(rdy0_a[k]),  32'(dn && m_own[k] == 0));
                chk("ready_1",          k, 32'(rdy1_a[k]),  32'(dn && m_own[k] == 1));
                chk("bus_enable",       k, 32'(ben_a[k]),   32'(acc));
                chk("bus_write_enable", k, 32'(bwe_a[k]),   32'(acc && m_we[k]));
                chk("bus_address",      k, 32'(badr_a[k]),  acc ? 32'(m_addr[k]) : 32'h0);
                chk("bus_data_in",      k, bdin_a[k],       acc ? m_wd[k] : 32'h0);
                chk("bus_write_mask",   k, 32'(bmsk_a[k]),  acc ? 32'(m_msk[k]) : 32'h0);
                chk("data_out_0",       k, dout0_a[k],      m_d0[k]);
                chk("data_out_1",       k, dout1_a[k],      m_d1[k]);
                if (rec && prev_g[k] == 2'b00 && grant_a[k] != 2'b00) begin
                    if (k == 0) gq_rr.push_back(grant_a[k]);
                    if (k == 1) gq_fp.push_back(grant_a[k]);
                end
                prev_g[k] = grant_a[k];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
        address_0 = 16'h0; address_1 = 16'h0;
        data_in_0 = 32'h0; data_in_1 = 32'h0;
        write_mask_0 = 4'h0; write_mask_1 = 4'h0;
        bus_data_out = 32'h0;
        step(3);
        chk("rst_grant",   0, 32'(grant_a[0]), 32'h0);
        chk("rst_ready_0", 0, 32'(rdy0_a[0]),  32'h0);
        chk("rst_dout_0",  0, dout0_a[0],      32'h0);
        chk("rst_ben",     0, 32'(ben_a[0]),   32'h0);

        // Read on port 0; cycle T is the current one
        reset = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; address_0 = 16'h4010; bus_data_out = 32'hDEADBEEF;
        step(1);
        chk("A_ben_T1",  0, 32'(ben_a[0]),  32'h1);
        chk("A_addr_T1", 0, 32'(badr_a[0]), 32'h4010);
        chk("A_w1_ben",  2, 32'(ben_a[2]),  32'h1);
        address_0 = 16'hFFFF;
        step(1);
        chk("A_ben_T2",    0, 32'(ben_a[0]),  32'h1);
        chk("A_addr_T2",   0, 32'(badr_a[0]), 32'h4010);
        chk("A_w1_ready",  2, 32'(rdy0_a[2]), 32'h1);
        chk("A_w1_dout",   2, dout0_a[2],     32'hDEADBEEF);
        step(1);
        chk("A_ready_T3",  0, 32'(rdy0_a[0]), 32'h1);
        chk("A_dout_T3",   0, dout0_a[0],     32'hDEADBEEF);
        chk("A_ben_T3",    0, 32'(ben_a[0]),  32'h0);
        req_0 = 1'b0;
        step(4);

        // Write on port 1
        req_1 = 1'b1; we_1 = 1'b1; address_1 = 16'hC004;
        data_in_1 = 32'h12345678; write_mask_1 = 4'b0011;
        step(1);
        chk("B_bwe_T1",  0, 32'(bwe_a[0]),  32'h1);
        chk("B_addr_T1", 0, 32'(badr_a[0]), 32'hC004);
        chk("B_data_T1", 0, bdin_a[0],      32'h12345678);
        chk("B_mask_T1", 0, 32'(bmsk_a[0]), 32'h3);
        step(1);
        chk("B_bwe_T2",  0, 32'(bwe_a[0]),  32'h1);
        step(1);
        chk("B_ready_T3", 0, 32'(rdy1_a[0]), 32'h1);
        chk("B_dout1",    0, dout1_a[0],     32'h0);
        chk("B_dout0",    0, dout0_a[0],     32'hDEADBEEF);
        req_1 = 1'b0; we_1 = 1'b0;
        step(4);

        // Both ports requesting continuously from reset release
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b0; we_1 = 1'b0;
        address_0 = 16'h0100; address_1 = 16'h0200;
        rec = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus_data_out = 32'hA500_0000 + 32'(i);
            step(1);
        end
        req_0 = 1'b0;
        step(10);
        rec = 1'b0;
        req_1 = 1'b0;
        step(6);
        chk("C_rr_count", 0, 32'(gq_rr.size() >= 4), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("C_rr_seq", 0, 32'((i < gq_rr.size()) ? gq_rr[i] : 2'b11),
                32'((i % 2 == 0) ? 2'b01 : 2'b10));
        end
        chk("C_fp_count", 1, 32'(gq_fp.size() >= 4), 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("C_fp_seq", 1, 32'((i < gq_fp.size()) ? gq_fp[i] : 2'b11), 32'h1);
        end
        chk("C_fp_last", 1, 32'((gq_fp.size() > 0) ? gq_fp[gq_fp.size() - 1] : 2'b00), 32'h2);

        // Reset during the second bus cycle of a read
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; address_0 = 16'h0040; bus_data_out = 32'h55AA55AA;
        step(2);
        reset = 1'b1;
        step(1);
        chk("D_ben",   0, 32'(ben_a[0]),   32'h0);
        chk("D_grant", 0, 32'(grant_a[0]), 32'h0);
        chk("D_ready", 0, 32'(rdy0_a[0]),  32'h0);
        chk("D_dout",  0, dout0_a[0],      32'h0);
        reset = 1'b0;
        req_0 = 1'b0;
        step(1);
        chk("D_ready_after", 0, 32'(rdy0_a[0]), 32'h0);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
